// File: rtl/pc_unit_if.sv
// Fetch-PC control bus: pipeline requests toward the PC unit and its registered
// fetch address / trap state back.
interface pc_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_req;
  logic             mret_req;
  logic             instr_len16;
  logic             halt_req;
  logic             resume;
  logic [XLEN-1:0]  pc_out;
  logic             pc_valid;
  logic [XLEN-1:0]  epc;
  logic             misalign_fault;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output stall, redirect_valid, redirect_target, trap_req, mret_req,
           instr_len16, halt_req, resume,
    input  pc_out, pc_valid, epc, misalign_fault, retire_cnt
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_req, mret_req,
           instr_len16, halt_req, resume,
    output pc_out, pc_valid, epc, misalign_fault, retire_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALT sequencing, prioritised redirect/trap/mret
// handling, misaligned-target trapping and a retired-instruction counter.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              C_EXT        = 0,
  parameter int              CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  pc_unit_if.slave    bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [XLEN-1:0]  r_epc, w_epc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fault, w_fault_nxt;
  logic             w_misalign;
  logic [XLEN-1:0]  w_inc;

  // Compressed ISA only needs halfword alignment; otherwise word alignment.
  assign w_misalign = (C_EXT != 0) ? bus.redirect_target[0]
                                   : (|bus.redirect_target[1:0]);
  assign w_inc      = ((C_EXT != 0) && bus.instr_len16) ? XLEN'(2) : XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.trap_req) begin
          w_epc_nxt = r_pc;
          w_pc_nxt  = TRAP_VECTOR;
        end else if (bus.mret_req) begin
          w_pc_nxt  = r_epc;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (bus.redirect_valid) begin
          if (w_misalign) begin
            // Bad target behaves like a trap, flagged for one cycle.
            w_epc_nxt   = r_pc;
            w_pc_nxt    = TRAP_VECTOR;
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt  = bus.redirect_target;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if (bus.halt_req) begin
          w_state_nxt = S_HALT;
        end else if (!bus.stall) begin
          w_pc_nxt  = r_pc + w_inc;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HALT: if (bus.resume) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign bus.pc_out         = r_pc;
  assign bus.pc_valid       = (r_state == S_RUN);
  assign bus.epc            = r_epc;
  assign bus.misalign_fault = r_fault;
  assign bus.retire_cnt     = r_cnt;
endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit: word-aligned instance (CNT_W=32) and a compressed
// instance with a 4-bit retire counter for wrap coverage.
module tb_pc_unit;
  logic clk, rst;
  int   n_cmp, n_err;

  pc_unit_if #(.XLEN(32), .CNT_W(32)) bus0();
  pc_unit_if #(.XLEN(32), .CNT_W(4))  bus1();

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
            .C_EXT(0), .CNT_W(32)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
            .C_EXT(1), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.stall = 0; bus0.redirect_valid = 0; bus0.redirect_target = '0;
    bus0.trap_req = 0; bus0.mret_req = 0; bus0.instr_len16 = 0;
    bus0.halt_req = 0; bus0.resume = 0;
  endtask

  task automatic idle1();
    bus1.stall = 0; bus1.redirect_valid = 0; bus1.redirect_target = '0;
    bus1.trap_req = 0; bus1.mret_req = 0; bus1.instr_len16 = 0;
    bus1.halt_req = 0; bus1.resume = 0;
  endtask

  task automatic chk0(input string tag, input logic [31:0] pc, input logic v,
                      input logic [31:0] ep, input logic [31:0] cnt, input logic f);
    chk({tag, ".pc"},    64'(bus0.pc_out), 64'(pc));
    chk({tag, ".valid"}, 64'(bus0.pc_valid), 64'(v));
    chk({tag, ".epc"},   64'(bus0.epc), 64'(ep));
    chk({tag, ".cnt"},   64'(bus0.retire_cnt), 64'(cnt));
    chk({tag, ".fault"}, 64'(bus0.misalign_fault), 64'(f));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    idle0(); idle1();
    rst = 1'b1;
    #3;
    chk0("rst_async", 32'h0, 0, 32'h0, 0, 0);
    step(); step();
    rst = 1'b0;

    // Power-up fetch sequence
    chk0("boot",  32'h0, 0, 32'h0, 0, 0);
    step(); chk0("run0", 32'h0, 1, 32'h0, 0, 0);
    step(); chk0("run1", 32'h4, 1, 32'h0, 1, 0);
    step(); chk0("run2", 32'h8, 1, 32'h0, 2, 0);

    // Trap beats redirect and stall in the same cycle
    bus0.redirect_valid = 1; bus0.redirect_target = 32'h40;
    bus0.stall = 1; bus0.trap_req = 1;
    step(); idle0();
    chk0("trap_prio", 32'h100, 1, 32'h8, 2, 0);
    bus0.mret_req = 1;
    step(); idle0();
    chk0("mret", 32'h8, 1, 32'h8, 3, 0);

    bus0.redirect_valid = 1; bus0.redirect_target = 32'h40;
    step(); idle0();
    chk0("redir", 32'h40, 1, 32'h8, 4, 0);
    bus0.stall = 1;
    step(); idle0();
    chk0("stall", 32'h40, 1, 32'h8, 4, 0);

    // Halfword-aligned target is misaligned without compressed support
    bus0.redirect_valid = 1; bus0.redirect_target = 32'h42;
    step(); idle0();
    chk0("misal", 32'h100, 1, 32'h40, 4, 1);
    step(); chk0("misal_clr", 32'h104, 1, 32'h40, 5, 0);

    bus0.redirect_valid = 1; bus0.redirect_target = 32'hFFFF_FFFC;
    step(); idle0();
    chk0("top", 32'hFFFF_FFFC, 1, 32'h40, 6, 0);
    step(); chk0("pc_wrap", 32'h0, 1, 32'h40, 7, 0);

    // HALT ignores everything but resume
    bus0.halt_req = 1;
    step(); idle0();
    chk0("halt", 32'h0, 0, 32'h40, 7, 0);
    bus0.trap_req = 1; bus0.redirect_valid = 1; bus0.redirect_target = 32'h80;
    step(); idle0();
    chk0("halt_ign", 32'h0, 0, 32'h40, 7, 0);
    bus0.resume = 1;
    step(); idle0();
    chk0("resume", 32'h0, 1, 32'h40, 7, 0);
    step(); chk0("post_res", 32'h4, 1, 32'h40, 8, 0);

    // Build epc=0x20, halt, then reset between edges with a request pending
    bus0.redirect_valid = 1; bus0.redirect_target = 32'h20;
    step(); idle0();
    bus0.trap_req = 1;
    step(); idle0();
    bus0.halt_req = 1;
    step(); idle0();
    chk0("pre_rst", 32'h100, 0, 32'h20, 9, 0);
    bus0.trap_req = 1;
    #2 rst = 1'b1;
    #1 chk0("rst_mid", 32'h0, 0, 32'h0, 0, 0);
    #1 rst = 1'b0;
    chk0("boot2", 32'h0, 0, 32'h0, 0, 0);
    step(); idle0();
    chk0("run_after", 32'h0, 1, 32'h0, 0, 0);
    step(); chk0("run_after1", 32'h4, 1, 32'h0, 1, 0);

    // Compressed instance: restart from reset
    idle1();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("c.pc0", 64'(bus1.pc_out), 64'h0);
    chk("c.cnt0", 64'(bus1.retire_cnt), 64'h0);
    bus1.redirect_valid = 1; bus1.redirect_target = 32'h42;
    step(); idle1();
    chk("c.redir_pc", 64'(bus1.pc_out), 64'h42);
    chk("c.redir_f", 64'(bus1.misalign_fault), 64'h0);
    chk("c.redir_cnt", 64'(bus1.retire_cnt), 64'h1);
    bus1.instr_len16 = 1;
    step(); idle1();
    chk("c.inc2", 64'(bus1.pc_out), 64'h44);
    step();
    chk("c.inc4", 64'(bus1.pc_out), 64'h48);
    bus1.redirect_valid = 1; bus1.redirect_target = 32'h45;
    step(); idle1();
    chk("c.misal_pc", 64'(bus1.pc_out), 64'h100);
    chk("c.misal_epc", 64'(bus1.epc), 64'h48);
    chk("c.misal_f", 64'(bus1.misalign_fault), 64'h1);
    chk("c.misal_cnt", 64'(bus1.retire_cnt), 64'h3);
    for (int i = 0; i < 12; i++) step();
    chk("c.cnt_max", 64'(bus1.retire_cnt), 64'hF);
    chk("c.f_clr", 64'(bus1.misalign_fault), 64'h0);
    step();
    chk("c.cnt_wrap", 64'(bus1.retire_cnt), 64'h0);
    chk("c.pc_end", 64'(bus1.pc_out), 64'h134);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
